// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scoreboard
//  Purpose  : Register-hazard scoreboard and single-entry issue register
//             between the decoder and execute stage. Tracks one busy bit per
//             architectural register, holds instructions until their operands
//             and destination are free, and drains the pipeline before
//             raising a one-cycle trap for illegal instructions.
//  Options  : SCOREBOARD_BYPASS_EN - let a same-cycle writeback release a
//             hazard (busy & ~wb_mask) instead of waiting for the registered
//             busy vector.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int REG_CNT     = 32,
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   dec_valid_in,
    output logic                   dec_ready_out,
    input  logic [ADDR_W-1:0]      reg_a_in,
    input  logic [ADDR_W-1:0]      reg_b_in,
    input  logic [ADDR_W-1:0]      reg_dest_in,
    input  logic                   use_a_in,
    input  logic                   use_b_in,
    input  logic                   wr_en_in,
    input  logic                   illeg_inst_flg_in,
    output logic                   issue_valid_out,
    input  logic                   issue_ready_in,
    output logic [ADDR_W-1:0]      issue_reg_a_out,
    output logic [ADDR_W-1:0]      issue_reg_b_out,
    output logic [ADDR_W-1:0]      issue_reg_dest_out,
    output logic                   issue_wr_en_out,
    input  logic                   wb_valid_in,
    input  logic [ADDR_W-1:0]      wb_reg_in,
    input  logic                   flush_in,
    output logic                   trap_out,
    output logic [REG_CNT-1:0]     busy_out,
    output logic [STALL_CNT_W-1:0] stall_cnt_out
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [REG_CNT-1:0]      busy_q, busy_d;
    logic [REG_CNT-1:0]      busy_chk;
    logic                    issue_valid_q, issue_valid_d;
    logic [ADDR_W-1:0]       issue_a_q, issue_a_d;
    logic [ADDR_W-1:0]       issue_b_q, issue_b_d;
    logic [ADDR_W-1:0]       issue_dest_q, issue_dest_d;
    logic                    issue_wr_q, issue_wr_d;
    logic [STALL_CNT_W-1:0]  stall_q, stall_d;
    logic                    hazard;
    logic                    ready;
    logic                    accept_legal;
    logic                    accept_illeg;

`ifdef SCOREBOARD_BYPASS_EN
    logic [REG_CNT-1:0]      wb_mask;

    // Writeback in flight this cycle is treated as already retired for hazard purposes
    always_comb begin
        wb_mask  = wb_valid_in ? (REG_CNT'(1) << wb_reg_in) : '0;
        busy_chk = busy_q & ~wb_mask;
    end
`else
    // Hazards are judged against the registered busy vector only
    always_comb begin
        busy_chk = busy_q;
    end
`endif

    // Hazard detection, decoder handshake and acceptance qualifiers
    always_comb begin
        hazard = (use_a_in && busy_chk[reg_a_in]) ||
                 (use_b_in && busy_chk[reg_b_in]) ||
                 (wr_en_in && busy_chk[reg_dest_in]);
        ready  = 1'b0;
        if (state_q == RUN && !flush_in) begin
            // Illegal instructions are swallowed immediately; they never occupy the issue slot
            ready = illeg_inst_flg_in ? 1'b1
                                      : (!hazard && (!issue_valid_q || issue_ready_in));
        end
        accept_legal = dec_valid_in && ready && !illeg_inst_flg_in;
        accept_illeg = dec_valid_in && ready &&  illeg_inst_flg_in;
    end

    // FSM next-state: flush overrides everything, illegal drains before trapping
    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (accept_illeg) state_d = DRAIN;
                DRAIN:   if (busy_q == '0 && !issue_valid_q) state_d = TRAP;
                TRAP:    state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Issue register, busy vector and stall counter next-state
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_dest_d  = issue_dest_q;
        issue_wr_d    = issue_wr_q;
        busy_d        = busy_q;
        stall_d       = stall_q;

        if (flush_in) begin
            issue_valid_d = 1'b0;
        end else if (accept_legal) begin
            issue_valid_d = 1'b1;
            issue_a_d     = reg_a_in;
            issue_b_d     = reg_b_in;
            issue_dest_d  = reg_dest_in;
            issue_wr_d    = wr_en_in;
        end else if (issue_ready_in) begin
            issue_valid_d = 1'b0;
        end

        // Clears first so that a same-cycle set of the same register wins
        if (wb_valid_in) begin
            busy_d[wb_reg_in] = 1'b0;
        end
        // Only a valid slot owns its destination; stale fields must not free an in-flight write
        if (flush_in && issue_valid_q && issue_wr_q) begin
            busy_d[issue_dest_q] = 1'b0;
        end
        if (accept_legal && wr_en_in) begin
            busy_d[reg_dest_in] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // Counts only genuine register-hazard stalls, not execute backpressure
        if (state_q == RUN && dec_valid_in && !illeg_inst_flg_in && !ready && hazard &&
            stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= RUN;
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_dest_q  <= '0;
            issue_wr_q    <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_dest_q  <= issue_dest_d;
            issue_wr_q    <= issue_wr_d;
            stall_q       <= stall_d;
        end
    end

    assign dec_ready_out      = ready;
    assign issue_valid_out    = issue_valid_q;
    assign issue_reg_a_out    = issue_a_q;
    assign issue_reg_b_out    = issue_b_q;
    assign issue_reg_dest_out = issue_dest_q;
    assign issue_wr_en_out    = issue_wr_q;
    assign trap_out           = (state_q == TRAP) && !flush_in;
    assign busy_out           = busy_q;
    assign stall_cnt_out      = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_scoreboard
//  Purpose  : Self-checking bench for issue_scoreboard. Expected issue records
//             are queued as instructions are accepted and compared when the
//             execute stage takes them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        dec_valid_in = 1'b0;
    logic        dec_ready_out;
    logic [4:0]  reg_a_in = '0, reg_b_in = '0, reg_dest_in = '0;
    logic        use_a_in = 1'b0, use_b_in = 1'b0, wr_en_in = 1'b0;
    logic        illeg_inst_flg_in = 1'b0;
    logic        issue_valid_out;
    logic        issue_ready_in = 1'b1;
    logic [4:0]  issue_reg_a_out, issue_reg_b_out, issue_reg_dest_out;
    logic        issue_wr_en_out;
    logic        wb_valid_in = 1'b0;
    logic [4:0]  wb_reg_in = '0;
    logic        flush_in = 1'b0;
    logic        trap_out;
    logic [31:0] busy_out;
    logic [15:0] stall_cnt_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

`ifdef SCOREBOARD_BYPASS_EN
    localparam int RAW_WAIT = 2;
    localparam int WAW_WAIT = 1;
`else
    localparam int RAW_WAIT = 3;
    localparam int WAW_WAIT = 2;
`endif

    issue_scoreboard #(.REG_CNT(32), .ADDR_W(5), .STALL_CNT_W(16)) dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .dec_valid_in       (dec_valid_in),
        .dec_ready_out      (dec_ready_out),
        .reg_a_in           (reg_a_in),
        .reg_b_in           (reg_b_in),
        .reg_dest_in        (reg_dest_in),
        .use_a_in           (use_a_in),
        .use_b_in           (use_b_in),
        .wr_en_in           (wr_en_in),
        .illeg_inst_flg_in  (illeg_inst_flg_in),
        .issue_valid_out    (issue_valid_out),
        .issue_ready_in     (issue_ready_in),
        .issue_reg_a_out    (issue_reg_a_out),
        .issue_reg_b_out    (issue_reg_b_out),
        .issue_reg_dest_out (issue_reg_dest_out),
        .issue_wr_en_out    (issue_wr_en_out),
        .wb_valid_in        (wb_valid_in),
        .wb_reg_in          (wb_reg_in),
        .flush_in           (flush_in),
        .trap_out           (trap_out),
        .busy_out           (busy_out),
        .stall_cnt_out      (stall_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare every instruction the execute stage takes against the queued expectation
    always @(negedge clk_in) begin
        if (reset_in && issue_valid_out && issue_ready_in) begin
            if (exp_q.size() == 0) begin
                check("issue_unexpected", {issue_reg_a_out, issue_reg_b_out, issue_reg_dest_out, issue_wr_en_out}, 64'hdead);
            end else begin
                check("issue_fields",
                      {issue_reg_a_out, issue_reg_b_out, issue_reg_dest_out, issue_wr_en_out},
                      exp_q.pop_front());
            end
        end
    end

    // Present one instruction until accepted; returns one time unit after the accepting edge
    task automatic send(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                        input logic ua, input logic ub, input logic we, input logic ill,
                        output int waited);
        dec_valid_in = 1'b1; reg_a_in = ra; reg_b_in = rb; reg_dest_in = rd;
        use_a_in = ua; use_b_in = ub; wr_en_in = we; illeg_inst_flg_in = ill;
        waited = 0;
        @(negedge clk_in);
        while (!dec_ready_out && waited < 40) begin
            waited++;
            @(negedge clk_in);
        end
        check("send_accept", dec_ready_out, 1);
        if (!ill && dec_ready_out) exp_q.push_back({ra, rb, rd, we});
        @(posedge clk_in); #1;
        dec_valid_in = 1'b0; illeg_inst_flg_in = 1'b0;
        use_a_in = 1'b0; use_b_in = 1'b0; wr_en_in = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid_in = 1'b1; wb_reg_in = r;
        @(posedge clk_in); #1;
        wb_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1, s0, pulses, at;

        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b1;
        @(negedge clk_in);
        check("rst_busy", busy_out, 0);
        check("rst_issue_valid", issue_valid_out, 0);
        check("rst_trap", trap_out, 0);
        check("rst_stall", stall_cnt_out, 0);
        @(posedge clk_in); #1;

        // Independent back-to-back stream
        send(5'd2, 5'd3, 5'd1, 1, 1, 1, 0, w0);
        send(5'd5, 5'd6, 5'd4, 1, 1, 1, 0, w1);
        @(negedge clk_in);
        check("indep_wait", w0 + w1, 0);
        check("indep_busy", busy_out, 32'h0000_0012);
        check("indep_stall", stall_cnt_out, 0);
        @(posedge clk_in); #1;
        wb(5'd4);
        wb(5'd5);
        wb(5'd0);
        @(negedge clk_in);
        check("wb_nonbusy_busy", busy_out, 32'h0000_0002);
        @(posedge clk_in); #1;
        wb(5'd1);

        // RAW dependency released by a writeback three cycles later
        s0 = int'(stall_cnt_out);
        send(5'd2, 5'd0, 5'd1, 1, 0, 1, 0, w0);
        fork
            send(5'd1, 5'd2, 5'd7, 1, 1, 1, 0, w1);
            begin repeat (2) @(posedge clk_in); #1; wb(5'd1); end
        join
        @(negedge clk_in);
        check("raw_wait", w1, RAW_WAIT);
        check("raw_stall", int'(stall_cnt_out) - s0, RAW_WAIT);
        check("raw_busy", busy_out, 32'h0000_0080);
        @(posedge clk_in); #1;

        // WAW on r7 released by a writeback in the second cycle
        fork
            send(5'd0, 5'd0, 5'd7, 0, 0, 1, 0, w1);
            begin @(posedge clk_in); #1; wb(5'd7); end
        join
        @(negedge clk_in);
        check("waw_wait", w1, WAW_WAIT);
        check("waw_stall", int'(stall_cnt_out) - s0, RAW_WAIT + WAW_WAIT);
        check("waw_busy", busy_out, 32'h0000_0080);
        @(posedge clk_in); #1;
        wb(5'd7);

        // Backpressure: non-hazarding input must not count as a stall
        issue_ready_in = 1'b0;
        send(5'd11, 5'd12, 5'd10, 1, 1, 1, 0, w0);
        s0 = int'(stall_cnt_out);
        dec_valid_in = 1'b1; reg_a_in = 5'd14; reg_b_in = 5'd15; reg_dest_in = 5'd13;
        use_a_in = 1'b1; use_b_in = 1'b1; wr_en_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            check("bp_ready", dec_ready_out, 0);
            check("bp_fields", {issue_valid_out, issue_reg_a_out, issue_reg_b_out, issue_reg_dest_out},
                  {1'b1, 5'd11, 5'd12, 5'd10});
            check("bp_stall", stall_cnt_out, s0);
            @(posedge clk_in); #1;
        end
        issue_ready_in = 1'b1;
        send(5'd14, 5'd15, 5'd13, 1, 1, 1, 0, w0);
        check("bp_release_wait", w0, 0);
        wb(5'd10);
        wb(5'd13);

        // Illegal instruction while r3 is busy
        send(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, w0);
        dec_valid_in = 1'b1; illeg_inst_flg_in = 1'b1; use_a_in = 1'b1; reg_a_in = 5'd3;
        @(negedge clk_in);
        check("ill_ready", dec_ready_out, 1);
        @(posedge clk_in); #1;
        dec_valid_in = 1'b0; illeg_inst_flg_in = 1'b0; use_a_in = 1'b0;
        pulses = 0; at = 0;
        for (int k = 1; k <= 10; k++) begin
            wb_valid_in = (k == 5); wb_reg_in = 5'd3;
            @(negedge clk_in);
            if (k == 1) check("ill_drain_ready", dec_ready_out, 0);
            if (trap_out) begin pulses++; at = k; end
            @(posedge clk_in); #1;
        end
        wb_valid_in = 1'b0;
        check("trap_pulses", pulses, 1);
        check("trap_cycle", at, 7);
        send(5'd1, 5'd2, 5'd5, 1, 1, 0, 0, w0);
        check("ill_back_to_run", w0, 0);

        // Flush of a pending r9 write while r8 is still in flight
        send(5'd1, 5'd2, 5'd8, 1, 1, 1, 0, w0);
        @(posedge clk_in); #1;
        issue_ready_in = 1'b0;
        send(5'd1, 5'd2, 5'd9, 1, 1, 1, 0, w0);
        check("pre_flush_busy", busy_out, 32'h0000_0300);
        flush_in = 1'b1;
        dec_valid_in = 1'b1; reg_a_in = 5'd1; reg_b_in = 5'd2; reg_dest_in = 5'd4; wr_en_in = 1'b1;
        @(negedge clk_in);
        check("flush_ready", dec_ready_out, 0);
        @(posedge clk_in); #1;
        flush_in = 1'b0; dec_valid_in = 1'b0; wr_en_in = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk_in);
        check("flush_issue_valid", issue_valid_out, 0);
        check("flush_busy", busy_out, 32'h0000_0100);
        @(posedge clk_in); #1;

        // Asynchronous reset in the middle of a drain
        send(5'd1, 5'd2, 5'd9, 1, 1, 1, 0, w0);
        send(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, w0);
        #2 reset_in = 1'b0;
        #1;
        check("arst_busy", busy_out, 0);
        check("arst_trap", trap_out, 0);
        check("arst_issue_valid", issue_valid_out, 0);
        check("arst_stall", stall_cnt_out, 0);
        exp_q.delete();
        #3 reset_in = 1'b1;
        issue_ready_in = 1'b1;
        @(posedge clk_in); #1;
        send(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, w0);
        check("arst_run_accept", w0, 0);
        repeat (3) @(posedge clk_in);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
